// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle ARM register-specified shift controller with carry-out
// Optional build macro SHIFT_SEQ_FASTPATH_EN: raises the per-cycle step limit to 31.

// Combinational shifter: one distance of 0-31 per use, no carry-out.
module shifter (
  input  logic [31:0] a,
  input  logic [2:0]  op,
  input  logic [4:0]  amt,
  input  logic        cin,
  output logic [31:0] y
);
  logic [63:0] rot;

  // Select the shift flavour; ops 5-7 pass the operand through.
  always_comb begin
    rot = {a, a} >> amt;
    case (op)
      3'd0:    y = a << amt;
      3'd1:    y = a >> amt;
      3'd2:    y = 32'($signed(a) >>> amt);
      3'd3:    y = rot[31:0];
      3'd4:    y = {cin, a[31:1]};
      default: y = a;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [2:0]  in_op,
  input  logic [7:0]  in_amount,
  input  logic        in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carry,
  output logic        busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

`ifdef SHIFT_SEQ_FASTPATH_EN
  localparam logic [5:0] LIMIT = 6'd31;
`else
  localparam logic [5:0] LIMIT = 6'(STEP);
`endif

  logic [1:0]  state;
  logic [31:0] v;
  logic [2:0]  op;
  logic        c;
  logic [5:0]  rem;

  logic [5:0]  d6;
  logic [31:0] y;
  logic [4:0]  lsl_idx;
  logic [4:0]  lsr_idx;
  logic        step_c;
  logic [5:0]  eff;
  logic        cap_c;

  // Distance for this step: whatever is left, capped at the step limit.
  always_comb begin
    d6 = (rem < LIMIT) ? rem : LIMIT;
  end

  shifter u_shifter (
    .a   (v),
    .op  (op),
    .amt (d6[4:0]),
    .cin (c),
    .y   (y)
  );

  // Carry-out of a step is the last bit that left the word.
  always_comb begin
    lsl_idx = 5'(6'd32 - d6);
    lsr_idx = d6[4:0] - 5'd1;
    case (op)
      3'd0:       step_c = v[lsl_idx];
      3'd1, 3'd2: step_c = v[lsr_idx];
      3'd3:       step_c = y[31];
      3'd4:       step_c = v[0];
      default:    step_c = c;
    endcase
  end

  // Effective amount: saturate where further shifting cannot change the result.
  // A ROR by a non-zero multiple of 32 leaves the value but sets carry to bit 31.
  always_comb begin
    case (in_op)
      3'd0, 3'd1: eff = (in_amount > 8'd33) ? 6'd33 : in_amount[5:0];
      3'd2:       eff = (in_amount > 8'd32) ? 6'd32 : in_amount[5:0];
      3'd3:       eff = {1'b0, in_amount[4:0]};
      3'd4:       eff = 6'd1;
      default:    eff = 6'd0;
    endcase
    cap_c = (in_op == 3'd3 && in_amount != 8'd0 && in_amount[4:0] == 5'd0) ? in_a[31] : in_carry;
  end

  // Capture, iterate, then hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      v     <= 32'd0;
      op    <= 3'd0;
      c     <= 1'b0;
      rem   <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            v     <= in_a;
            op    <= in_op;
            c     <= cap_c;
            rem   <= eff;
            state <= (eff == 6'd0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          v   <= y;
          c   <= step_c;
          rem <= rem - d6;
          if (rem == d6) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = v;
  assign out_carry  = c;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer (STEP=8)
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [2:0]  in_op;
  logic [7:0]  in_amount;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.STEP(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_op      (in_op),
    .in_amount  (in_amount),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, count step edges until out_valid, check result/carry/latency.
  // Leaves the DUT in DONE, sampled 1ns after the edge that entered it.
  task automatic issue(input string tag, input logic [31:0] a, input logic [2:0] op,
                       input logic [7:0] amt, input logic cin,
                       input logic [31:0] exp_res, input logic exp_c, input int exp_k);
    int n;
    in_a = a; in_op = op; in_amount = amt; in_carry = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " k"}, 32'(n), 32'(exp_k));
    check({tag, " result"}, out_result, exp_res);
    check({tag, " carry"}, {31'd0, out_carry}, {31'd0, exp_c});
  endtask

  task automatic finish_done(input string tag);
    @(posedge clk); #1;
    check({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_op = '0; in_amount = '0;
    in_carry = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst out_carry", {31'd0, out_carry}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    issue("lsl4",     32'h9000_0001, 3'd0, 8'd4,   1'b0, 32'h0000_0010, 1'b1, 1); finish_done("lsl4");
    issue("lsr32",    32'h8000_0000, 3'd1, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 4); finish_done("lsr32");
    issue("lsr40",    32'h8000_0000, 3'd1, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 5); finish_done("lsr40");
    issue("asr200",   32'hF000_0000, 3'd2, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 4); finish_done("asr200");
    issue("ror36",    32'h0000_00F1, 3'd3, 8'd36,  1'b1, 32'h1000_000F, 1'b0, 1); finish_done("ror36");
    issue("ror32",    32'h0000_00F1, 3'd3, 8'd32,  1'b1, 32'h0000_00F1, 1'b0, 0); finish_done("ror32");
    issue("ror64msb", 32'h8000_0000, 3'd3, 8'd64,  1'b0, 32'h8000_0000, 1'b1, 0); finish_done("ror64msb");
    issue("ror0",     32'h0000_00F1, 3'd3, 8'd0,   1'b1, 32'h0000_00F1, 1'b1, 0); finish_done("ror0");
    issue("rrx",      32'h0000_0003, 3'd4, 8'd9,   1'b1, 32'h8000_0001, 1'b1, 1); finish_done("rrx");
    issue("lsl32",    32'h0000_0001, 3'd0, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 4); finish_done("lsl32");
    issue("lsl33",    32'h0000_0001, 3'd0, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 5); finish_done("lsl33");
    issue("lsr9",     32'h0000_0300, 3'd1, 8'd9,   1'b0, 32'h0000_0001, 1'b1, 2); finish_done("lsr9");
    issue("asr31pos", 32'h7FFF_FFFF, 3'd2, 8'd31,  1'b1, 32'h0000_0000, 1'b1, 4); finish_done("asr31pos");
    issue("pass6",    32'h1234_5678, 3'd6, 8'd7,   1'b1, 32'h1234_5678, 1'b1, 0); finish_done("pass6");

    // Backpressure: DONE held while out_ready is low.
    out_ready = 1'b0;
    issue("bp", 32'h0000_00F0, 3'd1, 8'd4, 1'b0, 32'h0000_000F, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp result", out_result, 32'h0000_000F);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    finish_done("bp");

    // Reset in the middle of a SHIFT.
    in_a = 32'hFFFF_FFFF; in_op = 3'd1; in_amount = 8'd40; in_carry = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rs out_valid", {31'd0, out_valid}, 32'd0);
    check("rs busy", {31'd0, busy}, 32'd0);
    check("rs in_ready", {31'd0, in_ready}, 32'd1);
    check("rs out_result", out_result, 32'd0);
    issue("after rst", 32'h9000_0001, 3'd0, 8'd4, 1'b0, 32'h0000_0010, 1'b1, 1); finish_done("after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that drives the team's combinational `shifter` to execute ARM register-specified shifts with shift amounts of 0–255. It applies full ARM semantics for amounts ≥ 32 and computes the shifter carry-out, which the combinational shifter does not produce for LSL/LSR/ASR/ROR. It sits between the decode/operand stage and the ALU operand-2 input, with valid/ready handshakes on both sides.

## Interface
- STEP, 8, maximum shift distance applied per cycle; legal range 1–31.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  high exactly when state is IDLE.
- in_a  input  32  operand to shift.
- in_op  input  3  0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=RRX, 5–7 = pass-through.
- in_amount  input  8  shift amount (Rs[7:0]).
- in_carry  input  1  current C flag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  shifted operand.
- out_carry  output  1  shifter carry-out.
- busy  output  1  state is SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE. Reset values: out_valid=0, out_result=0, out_carry=0, busy=0, in_ready=1.
- IDLE: on in_valid, capture operand, op, carry, and effective amount E.
  - If E=0, go to DONE.
  - Otherwise go to SHIFT.
- Effective amount E:
  - LSL/LSR: min(amount, 33).
  - ASR: min(amount, 32).
  - ROR: amount[4:0].
  - RRX: 1, amount ignored.
  - Ops 5–7: 0.
- Zero-step results (ARM semantics):
  - amount=0 for any op, or ops 5–7: result=a, carry=in_carry.
  - ROR with amount≠0 and amount[4:0]=0: result=a, carry=a[31].
- SHIFT: each cycle, apply d = min(remaining, STEP) through one `shifter` instance and subtract d from remaining. Carry after each step is the last bit shifted out:
  - LSL: v[32-d].
  - LSR/ASR: v[d-1].
  - ROR: new v[31].
  - RRX: v[0]; result {carry, v[31:1]}.
  - When remaining reaches 0, go to DONE.
- Iterated steps produce ARM results naturally:
  - LSL/LSR by 32 → 0, carry = a[0] / a[31].
  - LSL/LSR by >32 → 0, carry 0.
  - ASR by ≥32 → all sign bits, carry = a[31].
- DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE.
  - No accept in the same cycle: in_ready is 0 in DONE.
- in_valid while not IDLE is ignored. The requester holds its request until in_ready.
- Reset asserted in any state drops the in-flight operation at that edge and restores reset values.

## Timing
- Request accepted at edge N.
- Number of steps k = ceil(E/STEP):
  - k=0: out_valid is high in the cycle after edge N.
  - k≥1: steps occur at edges N+1 … N+k; out_valid is high after edge N+k.
- Minimum request-to-request spacing is k+2 cycles with out_ready held high.
- out_result and out_carry are registered and change only on step edges or on capture.

## Configuration
- SHIFT_SEQ_FASTPATH_EN:
  - Defined: per-cycle step limit is 31 regardless of STEP. Any E≤31 completes in one step; E=32/33 completes in two.
  - Undefined: step limit is STEP.
  - Results and carries are identical in both builds; only latency differs.

## Test plan
- LSL a=0x9000_0001, amount 4, cin 0, STEP=8 → result 0x0000_0010, carry 1, out_valid after edge N+1.
- LSR a=0x8000_0000, amount 32 → result 0, carry 1, k=4. Amount 40 → result 0, carry 0, k=5.
- ASR a=0xF000_0000, amount 200 → 0xFFFF_FFFF, carry 1, k=4.
- ROR a=0x0000_00F1:
  - amount 36 → 0x1000_000F, carry 0.
  - amount 32 → 0x0000_00F1, carry 0, k=0.
  - amount 0, cin 1 → 0x0000_00F1, carry 1.
- RRX a=0x0000_0003, cin 1 → 0x8000_0001, carry 1, k=1.
- Backpressure and reset:
  - out_ready low 3 cycles in DONE → outputs stable, in_ready 0.
  - reset during SHIFT → next cycle out_valid 0, busy 0, in_ready 1.
  - next request completes correctly.
